// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR for the simple_cic decimator: 5-tap symmetric filter with one
// shared multiplier stepped over the three unique coefficients, one output per input strobe.
module cic_comp_fir #(
    parameter int in_width   = 18,
    parameter int out_width  = 18,
    parameter int coef_width = 18,
    parameter int shift      = 16,
    parameter int c0         = -4096,
    parameter int c1         = -8192,
    parameter int c2         = 90112
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        g_in,
    input  logic signed [in_width-1:0]  d_in,
    output logic                        g_out,
    output logic signed [out_width-1:0] d_out,
    output logic                        overrun
);

    localparam int pre_w  = in_width + 1;
    localparam int prod_w = pre_w + coef_width;
    localparam int acc_w  = prod_w + 2;

    localparam logic signed [acc_w:0] lp_half = (acc_w+1)'(64'sd1 <<< (shift - 1));
    localparam logic signed [acc_w:0] lp_max  = (acc_w+1)'((64'sd1 <<< (out_width - 1)) - 64'sd1);
    localparam logic signed [acc_w:0] lp_min  = (acc_w+1)'(-(64'sd1 <<< (out_width - 1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_P1,
        S_P2,
        S_OUT
    } state_t;

    state_t                         r_state;
    logic signed [in_width-1:0]     r_x [5];
    logic signed [acc_w-1:0]        r_acc;
    logic signed [out_width-1:0]    r_d_out;
    logic                           r_g_out;
    logic                           r_overrun;

    logic signed [in_width-1:0]     w_op_a;
    logic signed [in_width-1:0]     w_op_b;
    logic signed [coef_width-1:0]   w_coef;
    logic signed [pre_w-1:0]        w_pre;
    logic signed [prod_w-1:0]       w_prod;
    logic signed [acc_w:0]          w_rnd;
    logic signed [acc_w:0]          w_shr;
    logic signed [out_width-1:0]    w_sat;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_op_a = r_x[0];
        w_op_b = r_x[4];
        w_coef = coef_width'(c0);
        case (r_state)
            S_P1: begin
                w_op_a = r_x[1];
                w_op_b = r_x[3];
                w_coef = coef_width'(c1);
            end
            S_P2: begin
                w_op_a = r_x[2];
                w_op_b = '0;
                w_coef = coef_width'(c2);
            end
            default: ;
        endcase
    end

    assign w_pre  = pre_w'(w_op_a) + pre_w'(w_op_b);
    assign w_prod = prod_w'(w_pre) * prod_w'(w_coef);

    // Round half-up, then arithmetic shift; one extra bit keeps the rounding add from wrapping.
    assign w_rnd = (acc_w+1)'(r_acc) + lp_half;
    assign w_shr = w_rnd >>> shift;

    always_comb begin
        w_sat = out_width'(w_shr);
        if (w_shr > lp_max) begin
            w_sat = out_width'(lp_max);
        end else if (w_shr < lp_min) begin
            w_sat = out_width'(lp_min);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the delay line is only five registers and must start at zero, so it is reset like any other flop.
            for (int i = 0; i < 5; i++) begin
                r_x[i] <= '0;
            end
            r_acc     <= '0;
            r_d_out   <= '0;
            r_g_out   <= 1'b0;
            r_overrun <= 1'b0;
            r_state   <= S_IDLE;
        end else begin
            r_g_out <= 1'b0;
            if (g_in && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (g_in) begin
                        r_x[0] <= d_in;
                        for (int i = 1; i < 5; i++) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_state <= S_P0;
                    end
                end
                S_P0: begin
                    r_acc   <= acc_w'(w_prod);
                    r_state <= S_P1;
                end
                S_P1: begin
                    r_acc   <= r_acc + acc_w'(w_prod);
                    r_state <= S_P2;
                end
                S_P2: begin
                    r_acc   <= r_acc + acc_w'(w_prod);
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_d_out <= w_sat;
                    r_g_out <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign g_out   = r_g_out;
    assign d_out   = r_d_out;
    assign overrun = r_overrun;

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Gated-strobe, 5-tap symmetric FIR that compensates the passband droop of the `simple_cic` decimator and sits directly downstream of it. It consumes the decimator's `g_out`/`d_out` strobe/data pair and emits one filtered sample per accepted input strobe. A single shared multiplier is time-multiplexed over the three unique coefficients by a small sequencer.

## Interface
- `in_width`, 18: input sample width, signed; matches the `simple_cic` `out_width`.
- `out_width`, 18: output sample width, signed.
- `coef_width`, 18: coefficient width, signed.
- `shift`, 16: right shift applied to the accumulator; coefficients are Q(coef_width-shift).shift.
- `c0`, -4096: outer tap coefficient, applied to x0+x4.
- `c1`, -8192: middle tap coefficient, applied to x1+x3.
- `c2`, 90112: centre tap coefficient, applied to x2. Defaults satisfy 2·c0+2·c1+c2 = 65536, giving unity DC gain.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `g_in`  in  1  input strobe; `d_in` is valid when high.
- `d_in`  in  in_width  signed input sample.
- `g_out`  out  1  one-cycle output strobe.
- `d_out`  out  out_width  signed filtered sample; held between strobes.
- `overrun`  out  1  sticky flag; a strobe arrived while the block was busy.

## Operation
- Delay line x0..x4 holds signed samples, with x0 the newest.
- Sequencer states: IDLE → P0 → P1 → P2 → OUT → IDLE. It advances one state per clock and never stalls.
- IDLE with `g_in`=1: shift `d_in` into x0 (x0→x1→…→x4, x4 discarded), then go to P0. Without `g_in`, remain in IDLE.
- P0: acc ← c0·(x0+x4).
- P1: acc ← acc + c1·(x1+x3).
- P2: acc ← acc + c2·(x2 sign-extended).
- OUT: compute r = (acc + 2^(shift-1)) >>> shift, an arithmetic shift with round-half-up. Saturate r to [-2^(out_width-1), 2^(out_width-1)-1] and register it to `d_out`. Pulse `g_out`. Return to IDLE.
- Widths:
  - pre-add: in_width+1
  - product: in_width+1+coef_width
  - acc: product width + 2 guard bits, so it never wraps.
- `g_in` in any state other than IDLE:
  - the sample is dropped and the delay line is untouched;
  - the sequence in progress completes normally;
  - `overrun` ← 1, and it stays set until reset.
- Reset has priority over everything. In that cycle it clears:
  - x0..x4, acc, `d_out` = 0, `g_out` = 0, `overrun` = 0;
  - state → IDLE.

  A sequence interrupted by reset produces no `g_out`. A `g_in` coincident with reset is ignored.

## Timing
- Reset values: `g_out`=0, `d_out`=0, `overrun`=0, state IDLE, delay line zero.
- `g_in` sampled at edge k produces `g_out` high for exactly one cycle, from edge k+4 to edge k+5. `d_out` changes only at edge k+4.
- Fixed latency of 4 clocks.
- Minimum `g_in` spacing is 5 clocks (acceptance at edges k and k+5 is legal). A strobe at k+1 through k+4 is an overrun.
- `simple_cic` with cic_n ≥ 5 and any `g_in` duty cycle always meets the spacing.
- The first four outputs after reset reflect the zero-filled delay line (start-up transient); there is no output suppression.

## Test plan
- **DC step:** reset, then `d_in`=1000 strobed every 8 clocks. Required `d_out` sequence: -62, -187, 1188, 1063, then 1000 on every subsequent strobe. `overrun`=0 throughout.
- **Impulse:** `d_in`=32768 for one strobe, 0 thereafter. Required `d_out` sequence: -2048, -4096, 45056, -4096, -2048, 0, 0. Each value must be accompanied by a single-cycle `g_out` exactly 4 clocks after its `g_in`.
- **Saturation:** alternating `d_in`=+131071/-131071 every 8 clocks. After the fifth strobe, `d_out` must alternate between 131071 and -131072 (Nyquist gain 1.5, clipped), with no wrap.
- **Overrun:** strobes at edges k and k+3. Required response:
  - exactly one `g_out`, at k+4, carrying a value computed from the k sample only;
  - `overrun`=1 from k+4 onward and still 1 after 20 idle clocks.
- **Reset mid-operation:** strobe at k, `reset` at k+2. Required response:
  - no `g_out` at k+4;
  - `d_out`=0 and `overrun`=0;
  - the next strobe behaves like the first sample after reset.
- **Back-to-back at maximum rate:** `g_in` every 5 clocks for 50 samples of a ramp. Required response:
  - `g_out` every 5 clocks;
  - `overrun` stays 0;
  - `d_out` matches the bit-exact model, including round-half-up on negative values.
